eth_gmii_tx_framer: RTL and testbench

Transmit-side GMII framer for the 1G MAC path. It consumes an 8-bit AXI-Stream frame in the tx_clk domain, normally from the TX async FIFO output. It emits GMII bytes with preamble/SFD, optional zero padding, CRC-32 FCS and an enforced inter-frame gap. It is the transmit counterpart to the GMII receive deframer and sits between the TX FIFO and the RGMII/GMII PHY interface logic.

---
 rtl/eth_gmii_tx_framer.sv | 234 +++++++++++++++++++++++
 tb/tb_eth_gmii_tx_framer.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_gmii_tx_framer.sv
// eth_gmii_tx_framer
//
// Transmit-side GMII framer for the 1G MAC path. Takes an 8-bit AXI-Stream
// frame in the tx_clk domain (normally the TX async FIFO output) and emits
// GMII bytes: 7x 0x55 preamble, 0xD5 SFD, payload, optional zero padding,
// CRC-32 FCS (LSB first), followed by an enforced inter-frame gap.
//
// Build option:
//   ETH_GMII_TX_PAD_EN  defined   -> short frames are zero-padded so that
//                                    payload+pad+FCS reaches MIN_FRAME_LENGTH.
//                       undefined -> no PAD state; FCS follows the last
//                                    payload byte and MIN_FRAME_LENGTH is unused.
//
// Ports:
//   tx_clk, tx_rst           clock (rising edge), async active-high reset
//   clk_enable               byte strobe; nothing advances while it is 0
//   s_axis_t*                8-bit frame input; tuser marks a bad frame on tlast
//   ifg_delay                requested IFG in byte times (floored at 12)
//   gmii_txd/tx_en/tx_er     registered GMII transmit outputs
//   start_packet             pulse with the first preamble byte
//   error_underflow          pulse with the byte that aborts an underflowed frame
//   state_dbg                current FSM state encoding, for observation only
//
// Handshake: a payload byte transfers on a rising tx_clk edge where
// s_axis_tvalid & s_axis_tready are both 1. s_axis_tready depends only on the
// FSM state and clk_enable, never on s_axis_tvalid.

module eth_gmii_tx_framer #(
    parameter int MIN_FRAME_LENGTH = 64
) (
    input  logic       tx_clk,
    input  logic       tx_rst,
    input  logic       clk_enable,
    input  logic [7:0] s_axis_tdata,
    input  logic       s_axis_tvalid,
    output logic       s_axis_tready,
    input  logic       s_axis_tlast,
    input  logic       s_axis_tuser,
    input  logic [7:0] ifg_delay,
    output logic [7:0] gmii_txd,
    output logic       gmii_tx_en,
    output logic       gmii_tx_er,
    output logic       start_packet,
    output logic       error_underflow,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PREAMBLE = 3'd1,
        PAYLOAD  = 3'd2,
        PAD      = 3'd3,
        FCS      = 3'd4,
        WAIT_END = 3'd5,
        IFG      = 3'd6
    } state_t;

    // One byte of the reflected CRC-32 (poly 0xEDB88320), LSB-first.
    function automatic logic [31:0] crc_next(input logic [31:0] crc_in, input logic [7:0] data);
        logic [31:0] c;
        c = crc_in ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return c;
    endfunction

    state_t      state, state_d;
    logic [2:0]  pre_cnt, pre_cnt_d;       // preamble bytes already driven
    logic [15:0] byte_cnt, byte_cnt_d;     // payload (+pad) bytes, saturating
    logic [1:0]  fcs_idx, fcs_idx_d;
    logic [7:0]  ifg_cnt, ifg_cnt_d;
    logic [31:0] crc, crc_d;

    logic [7:0]  txd_d;
    logic        tx_en_d, tx_er_d, start_d, underflow_d;

    logic [15:0] byte_cnt_inc;
    logic [7:0]  ifg_load;
    logic [31:0] fcs;
    logic        pad_needed;

    assign byte_cnt_inc = (byte_cnt == 16'hFFFF) ? byte_cnt : byte_cnt + 16'd1;
    assign ifg_load     = (ifg_delay < 8'd12) ? 8'd12 : ifg_delay;
    assign fcs          = ~crc;
    assign state_dbg    = state;

`ifdef ETH_GMII_TX_PAD_EN
    // Payload+pad byte count at which FCS may start.
    localparam int unsigned PAD_LIMIT = (MIN_FRAME_LENGTH > 4) ? MIN_FRAME_LENGTH - 4 : 0;
    // Evaluated against the count including the byte handled this cycle.
    assign pad_needed = ({16'h0, byte_cnt_inc} < PAD_LIMIT);
`else
    assign pad_needed = 1'b0;
`endif

    always_comb begin
        state_d       = state;
        pre_cnt_d     = pre_cnt;
        byte_cnt_d    = byte_cnt;
        fcs_idx_d     = fcs_idx;
        ifg_cnt_d     = ifg_cnt;
        crc_d         = crc;
        txd_d         = 8'h00;
        tx_en_d       = 1'b0;
        tx_er_d       = 1'b0;
        start_d       = 1'b0;
        underflow_d   = 1'b0;
        s_axis_tready = 1'b0;

        case (state)
            IDLE: begin
                if (s_axis_tvalid) begin
                    state_d    = PREAMBLE;
                    txd_d      = 8'h55;
                    tx_en_d    = 1'b1;
                    start_d    = 1'b1;
                    pre_cnt_d  = 3'd1;
                    byte_cnt_d = 16'd0;
                    crc_d      = 32'hFFFF_FFFF;
                end
            end

            PREAMBLE: begin
                tx_en_d = 1'b1;
                if (pre_cnt == 3'd7) begin
                    txd_d   = 8'hD5;
                    state_d = PAYLOAD;
                end else begin
                    txd_d     = 8'h55;
                    pre_cnt_d = pre_cnt + 3'd1;
                end
            end

            PAYLOAD: begin
                s_axis_tready = clk_enable;
                tx_en_d       = 1'b1;
                if (s_axis_tvalid) begin
                    txd_d      = s_axis_tdata;
                    crc_d      = crc_next(crc, s_axis_tdata);
                    byte_cnt_d = byte_cnt_inc;
                    if (s_axis_tlast) begin
                        if (s_axis_tuser) begin
                            // Bad frame: mark the last byte and drop the FCS.
                            tx_er_d   = 1'b1;
                            state_d   = IFG;
                            ifg_cnt_d = ifg_load;
                        end else if (pad_needed) begin
                            state_d = PAD;
                        end else begin
                            state_d   = FCS;
                            fcs_idx_d = 2'd0;
                        end
                    end
                end else begin
                    // Source ran dry mid-frame: poison the frame and drain it.
                    tx_er_d     = 1'b1;
                    underflow_d = 1'b1;
                    state_d     = WAIT_END;
                end
            end

`ifdef ETH_GMII_TX_PAD_EN
            PAD: begin
                tx_en_d    = 1'b1;
                crc_d      = crc_next(crc, 8'h00);
                byte_cnt_d = byte_cnt_inc;
                if (!pad_needed) begin
                    state_d   = FCS;
                    fcs_idx_d = 2'd0;
                end
            end
`endif

            FCS: begin
                tx_en_d   = 1'b1;
                txd_d     = fcs[8*fcs_idx +: 8];
                fcs_idx_d = fcs_idx + 2'd1;
                if (fcs_idx == 2'd3) begin
                    state_d   = IFG;
                    ifg_cnt_d = ifg_load;
                end
            end

            WAIT_END: begin
                s_axis_tready = clk_enable;
                if (s_axis_tvalid && s_axis_tlast) begin
                    state_d   = IFG;
                    ifg_cnt_d = ifg_load;
                end
            end

            IFG: begin
                ifg_cnt_d = ifg_cnt - 8'd1;
                if (ifg_cnt <= 8'd1) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge tx_clk or posedge tx_rst) begin
        if (tx_rst) begin
            state           <= IDLE;
            pre_cnt         <= 3'd0;
            byte_cnt        <= 16'd0;
            fcs_idx         <= 2'd0;
            ifg_cnt         <= 8'd0;
            crc             <= 32'hFFFF_FFFF;
            gmii_txd        <= 8'h00;
            gmii_tx_en      <= 1'b0;
            gmii_tx_er      <= 1'b0;
            start_packet    <= 1'b0;
            error_underflow <= 1'b0;
        end else if (clk_enable) begin
            state           <= state_d;
            pre_cnt         <= pre_cnt_d;
            byte_cnt        <= byte_cnt_d;
            fcs_idx         <= fcs_idx_d;
            ifg_cnt         <= ifg_cnt_d;
            crc             <= crc_d;
            gmii_txd        <= txd_d;
            gmii_tx_en      <= tx_en_d;
            gmii_tx_er      <= tx_er_d;
            start_packet    <= start_d;
            error_underflow <= underflow_d;
        end
    end

endmodule

// File: tb/tb_eth_gmii_tx_framer.sv
// Self-checking bench for eth_gmii_tx_framer.
// Driver tasks push the expected GMII byte stream (one entry per enabled
// byte slot) and the expected inter-frame gap; a monitor pops and compares
// every enabled slot independently of the driver.

module tb_eth_gmii_tx_framer;

    localparam int MIN_LEN  = 64;
    localparam int K_NORMAL = 0;
    localparam int K_TUSER  = 1;
    localparam int K_UNDER  = 2;
`ifdef ETH_GMII_TX_PAD_EN
    localparam bit PAD_BUILD = 1'b1;
`else
    localparam bit PAD_BUILD = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic       tx_clk;
    logic       tx_rst;
    logic       clk_enable;
    logic [7:0] s_axis_tdata;
    logic       s_axis_tvalid;
    logic       s_axis_tready;
    logic       s_axis_tlast;
    logic       s_axis_tuser;
    logic [7:0] ifg_delay;
    logic [7:0] gmii_txd;
    logic       gmii_tx_en;
    logic       gmii_tx_er;
    logic       start_packet;
    logic       error_underflow;
    logic [2:0] state_dbg;

    initial tx_clk = 1'b0;
    always #5 tx_clk = ~tx_clk;

    eth_gmii_tx_framer #(.MIN_FRAME_LENGTH(MIN_LEN)) dut (
        .tx_clk          (tx_clk),
        .tx_rst          (tx_rst),
        .clk_enable      (clk_enable),
        .s_axis_tdata    (s_axis_tdata),
        .s_axis_tvalid   (s_axis_tvalid),
        .s_axis_tready   (s_axis_tready),
        .s_axis_tlast    (s_axis_tlast),
        .s_axis_tuser    (s_axis_tuser),
        .ifg_delay       (ifg_delay),
        .gmii_txd        (gmii_txd),
        .gmii_tx_en      (gmii_tx_en),
        .gmii_tx_er      (gmii_tx_er),
        .start_packet    (start_packet),
        .error_underflow (error_underflow),
        .state_dbg       (state_dbg)
    );

    // ---------------- scoreboard state ----------------
    // entry = {error_underflow, start_packet, tx_en, tx_er, txd}
    logic [11:0] exp_q[$];
    int          gap_q[$];
    logic [7:0]  pay[$];
    logic [7:0]  fcs_data[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          prev_gap = -1;
    int          ce_mode  = 0;
    logic        last_en  = 1'b0;
    time         tv_time;
    time         last_start_time;

    always @(posedge tx_clk) last_en <= clk_enable;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out waiting on DUT at %0t", name, $time);
    endtask

    // Reference CRC-32 (reflected, init all ones), returns the FCS value.
    function automatic logic [31:0] fcs_model();
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        foreach (fcs_data[i]) begin
            c = c ^ {24'h0, fcs_data[i]};
            for (int k = 0; k < 8; k++) begin
                c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
            end
        end
        return ~c;
    endfunction

    // ---------------- clock-enable pattern ----------------
    initial begin
        clk_enable = 1'b1;
        forever begin
            @(negedge tx_clk);
            case (ce_mode)
                0:       clk_enable = 1'b1;
                1:       clk_enable = ~clk_enable;
                default: clk_enable = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // ---------------- monitor ----------------
    initial begin
        logic [11:0] obs;
        logic [11:0] e;
        int          gap_cnt;
        bit          have_prev;
        gap_cnt   = 0;
        have_prev = 0;
        forever begin
            @(negedge tx_clk);
            if (tx_rst) begin
                have_prev = 0;
                gap_cnt   = 0;
            end else if (last_en) begin
                obs = {error_underflow, start_packet, gmii_tx_en, gmii_tx_er, gmii_txd};
                if (error_underflow || start_packet || gmii_tx_en || gmii_tx_er) begin
                    if (start_packet) begin
                        last_start_time = $time;
                        if (have_prev) begin
                            if (gap_q.size() == 0) begin
                                n_checks++;
                                n_fail++;
                                $display("FAIL ifg_gap: frame started with no gap expectation, gap=%0d", gap_cnt);
                            end else begin
                                check("ifg_gap", gap_cnt, gap_q.pop_front());
                            end
                        end
                        have_prev = 1;
                    end
                    gap_cnt = 0;
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL gmii_slot: unexpected active byte 0x%0h at %0t", obs, $time);
                    end else begin
                        e = exp_q.pop_front();
                        check("gmii_slot", obs, e);
                    end
                end else begin
                    gap_cnt++;
                    check("idle_slot", obs, 12'h000);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Present one beat at a negedge; return at the negedge after the edge
    // that took it. With valid=0 this waits for the cycle where the DUT
    // is ready but starved.
    task automatic put_beat(input logic v, input logic [7:0] d, input logic l, input logic u);
        int t;
        t             = 0;
        s_axis_tvalid = v;
        s_axis_tdata  = d;
        s_axis_tlast  = l;
        s_axis_tuser  = u;
        forever begin
            #1;
            if (s_axis_tready) begin
                @(negedge tx_clk);
                break;
            end
            @(negedge tx_clk);
            t++;
            if (t > 4000) begin
                timeout_fail("beat_accept");
                break;
            end
        end
    endtask

    task automatic wait_en(input int n);
        int c;
        c = 0;
        while (c < n) begin
            #1;
            if (clk_enable) c++;
            @(negedge tx_clk);
        end
    endtask

    task automatic send_frame(input int kind, input int uf_at, input int ifg_val,
                              input bit known_fcs, input bit hold_tail);
        int          len;
        int          pad;
        int          eff;
        int          sent;
        logic [31:0] f;
        len = pay.size();
        pad = 0;
        if (PAD_BUILD && kind == K_NORMAL && len < MIN_LEN - 4) pad = MIN_LEN - 4 - len;
        eff = (ifg_val > 12) ? ifg_val : 12;
        if (prev_gap >= 0) gap_q.push_back(prev_gap);
        ifg_delay = 8'(ifg_val);

        exp_q.push_back({4'b0110, 8'h55});
        repeat (6) exp_q.push_back({4'b0010, 8'h55});
        exp_q.push_back({4'b0010, 8'hD5});
        sent = (kind == K_UNDER) ? uf_at : len;
        for (int i = 0; i < sent; i++) begin
            if (kind == K_TUSER && i == len - 1) exp_q.push_back({4'b0011, pay[i]});
            else                                 exp_q.push_back({4'b0010, pay[i]});
        end
        if (kind == K_UNDER) exp_q.push_back({4'b1011, 8'h00});
        if (kind == K_NORMAL) begin
            fcs_data = pay;
            repeat (pad) begin
                fcs_data.push_back(8'h00);
                exp_q.push_back({4'b0010, 8'h00});
            end
            if (known_fcs && !PAD_BUILD) f = 32'hCBF43926;
            else                         f = fcs_model();
            for (int b = 0; b < 4; b++) exp_q.push_back({4'b0010, f[8*b +: 8]});
        end

        tv_time = $time;
        for (int i = 0; i < sent; i++) begin
            put_beat(1'b1, pay[i], (i == len - 1), (kind == K_TUSER && i == len - 1));
        end
        if (kind == K_UNDER) begin
            put_beat(1'b0, 8'h00, 1'b0, 1'b0);
            for (int i = uf_at; i < len; i++) begin
                put_beat(1'b1, pay[i], (i == len - 1), 1'($urandom_range(0, 1)));
            end
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = 1'b0;
        prev_gap = eff + ((kind == K_UNDER) ? (len - uf_at) : 0);
        // Let the DUT enter IFG before anything touches ifg_delay again.
        if (!hold_tail) wait_en((kind == K_NORMAL) ? pad + 5 : 1);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_txd"},   gmii_txd,        8'h00);
        check({tag, "_en"},    gmii_tx_en,      1'b0);
        check({tag, "_er"},    gmii_tx_er,      1'b0);
        check({tag, "_start"}, start_packet,    1'b0);
        check({tag, "_uf"},    error_underflow, 1'b0);
        check({tag, "_ready"}, s_axis_tready,   1'b0);
    endtask

    // ---------------- main stimulus ----------------
    initial begin
        string s;
        int    len;
        int    kind;
        int    uf;
        int    pad;
        int    t;

        tx_rst        = 1'b1;
        s_axis_tdata  = 8'h00;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = 1'b0;
        ifg_delay     = 8'd12;
        repeat (3) @(negedge tx_clk);
        #1;
        check_outputs_zero("reset");
        @(negedge tx_clk);
        tx_rst = 1'b0;
        repeat (2) @(negedge tx_clk);

        // Known vector "123456789"
        s = "123456789";
        pay.delete();
        for (int i = 0; i < s.len(); i++) pay.push_back(s[i]);
        send_frame(K_NORMAL, 0, 12, 1'b1, 1'b0);

        // 60-byte incrementing payload, minimum IFG
        pay.delete();
        for (int i = 0; i < 60; i++) pay.push_back(8'(i));
        send_frame(K_NORMAL, 0, 12, 1'b0, 1'b0);

        // One-byte payload, ifg_delay below the floor
        pay.delete();
        pay.push_back(8'hA5);
        send_frame(K_NORMAL, 0, 3, 1'b0, 1'b0);

        // Underflow after 5 bytes of a 10-byte frame
        pay.delete();
        for (int i = 0; i < 10; i++) pay.push_back(8'($urandom));
        send_frame(K_UNDER, 5, 12, 1'b0, 1'b0);

        // Bad frame flagged with tuser on byte 20, long IFG
        pay.delete();
        for (int i = 0; i < 20; i++) pay.push_back(8'($urandom));
        send_frame(K_TUSER, 0, 30, 1'b0, 1'b0);

        // Toggling clk_enable
        ce_mode = 1;
        pay.delete();
        for (int i = 0; i < 20; i++) pay.push_back(8'($urandom));
        send_frame(K_NORMAL, 0, 14, 1'b0, 1'b0);
        s = "123456789";
        pay.delete();
        for (int i = 0; i < s.len(); i++) pay.push_back(s[i]);
        send_frame(K_NORMAL, 0, 12, 1'b1, 1'b0);

        // Randomized frames
        for (int f = 0; f < 20; f++) begin
            ce_mode = $urandom_range(0, 2);
            len     = $urandom_range(1, 80);
            kind    = ($urandom_range(0, 9) < 6) ? K_NORMAL : (($urandom_range(0, 1) == 1) ? K_TUSER : K_UNDER);
            if (kind == K_UNDER && len < 2) kind = K_TUSER;
            uf      = (kind == K_UNDER) ? $urandom_range(1, len - 1) : 0;
            pay.delete();
            repeat (len) pay.push_back(8'($urandom));
            send_frame(kind, uf, $urandom_range(0, 24), 1'b0, 1'b0);
        end

        // Reset while the second FCS byte is on the wire
        ce_mode = 0;
        pay.delete();
        for (int i = 0; i < 9; i++) pay.push_back(8'($urandom));
        send_frame(K_NORMAL, 0, 12, 1'b0, 1'b1);
        pad = PAD_BUILD ? (MIN_LEN - 4 - 9) : 0;
        wait_en(pad + 2);
        #2;
        tx_rst = 1'b1;
        #1;
        check_outputs_zero("mid_fcs_reset");
        exp_q.delete();
        gap_q.delete();
        prev_gap = -1;
        repeat (2) @(negedge tx_clk);
        tx_rst = 1'b0;

        pay.delete();
        for (int i = 0; i < 12; i++) pay.push_back(8'($urandom));
        send_frame(K_NORMAL, 0, 12, 1'b0, 1'b0);
        check("restart_latency", 32'(last_start_time - tv_time), 32'd10);

        // Drain
        t = 0;
        while (exp_q.size() != 0 && t < 3000) begin
            @(negedge tx_clk);
            t++;
        end
        if (exp_q.size() != 0) timeout_fail("drain");
        check("exp_q_empty", exp_q.size(), 0);
        repeat (20) @(negedge tx_clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
